// File: rtl/dual_rail_pkg.sv
// Shared helpers for dual-rail channel adapters: FSM state encoding and the
// per-bit dual-rail encoder (d -> {d0, d1} = {~d, d}).
package dual_rail_pkg;

   typedef logic [1:0] dr_state_t;

   localparam dr_state_t StWaitLow  = 2'd0;
   localparam dr_state_t StIdle     = 2'd1;
   localparam dr_state_t StWaitData = 2'd2;
   localparam dr_state_t StDrive    = 2'd3;

   // Returns {zero rail, one rail} for a single data bit.
   function automatic logic [1:0] dr_encode_bit(input logic d);
      return {~d, d};
   endfunction

endpackage

// File: rtl/dual_pull_resp_fifo.sv
// Input buffer for dual_pull_resp: DEPTH-entry FIFO with a registered ready
// flag that is low during reset and whenever the FIFO is full.
module dual_pull_resp_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CntW-1:0]  count_o,
   output logic             ready_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             ready_q, ready_d;
   logic             push, pop;

   // Ready is registered from the count, so it stays low on a full cycle even if a pop occurs.
   assign push = push_i & ready_q;
   assign pop  = pop_i & (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      ready_d = (count_d < CntW'(DEPTH));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign ready_o = ready_q;

endmodule

// File: rtl/dual_pull_resp.sv
// Passive data-bearing end of a four-phase dual-rail pull channel, fed by a FIFO.
// Define DUAL_PULL_RESP_SYNC_EN to pass req through a two-flop synchronizer.
module dual_pull_resp
   import dual_rail_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             initialise,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             req,
   output logic [WIDTH-1:0] ack_d0,
   output logic [WIDTH-1:0] ack_d1,
   output logic [15:0]      rsp_count
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic             req_s;
   logic             pop;
   logic             has_data;
   logic [WIDTH-1:0] fifo_rdata;
   logic [CntW-1:0]  fifo_count;
   logic [WIDTH-1:0] enc_d0, enc_d1;

   dr_state_t        state_q, state_d;
   logic [WIDTH-1:0] ack_d0_q, ack_d0_d;
   logic [WIDTH-1:0] ack_d1_q, ack_d1_d;
   logic [15:0]      rsp_count_q, rsp_count_d;

`ifdef DUAL_PULL_RESP_SYNC_EN
   logic req_s1_q, req_s2_q;

   always_ff @(posedge clk) begin
      if (initialise) begin
         req_s1_q <= 1'b0;
         req_s2_q <= 1'b0;
      end else begin
         req_s1_q <= req;
         req_s2_q <= req_s1_q;
      end
   end

   assign req_s = req_s2_q;
`else
   assign req_s = req;
`endif

   dual_pull_resp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CntW  (CntW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (initialise),
      .push_i  (in_valid),
      .pop_i   (pop),
      .wdata_i (in_data),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .ready_o (in_ready)
   );

   assign has_data = (fifo_count != '0);

   always_comb begin
      enc_d0 = '0;
      enc_d1 = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         {enc_d0[i], enc_d1[i]} = dr_encode_bit(fifo_rdata[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      ack_d0_d    = ack_d0_q;
      ack_d1_d    = ack_d1_q;
      rsp_count_d = rsp_count_q;
      pop         = 1'b0;
      case (state_q)
         StWaitLow: begin
            if (!req_s) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (req_s) begin
               if (has_data) begin
                  pop      = 1'b1;
                  ack_d0_d = enc_d0;
                  ack_d1_d = enc_d1;
                  state_d  = StDrive;
               end else begin
                  state_d = StWaitData;
               end
            end
         end
         // A falling req here is a protocol violation and deliberately ignored.
         StWaitData: begin
            if (has_data) begin
               pop      = 1'b1;
               ack_d0_d = enc_d0;
               ack_d1_d = enc_d1;
               state_d  = StDrive;
            end
         end
         StDrive: begin
            if (!req_s) begin
               ack_d0_d    = '0;
               ack_d1_d    = '0;
               rsp_count_d = rsp_count_q + 16'd1;
               state_d     = StIdle;
            end
         end
         default: state_d = StWaitLow;
      endcase
   end

   always_ff @(posedge clk) begin
      if (initialise) begin
         state_q     <= StWaitLow;
         ack_d0_q    <= '0;
         ack_d1_q    <= '0;
         rsp_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ack_d0_q    <= ack_d0_d;
         ack_d1_q    <= ack_d1_d;
         rsp_count_q <= rsp_count_d;
      end
   end

   assign ack_d0    = ack_d0_q;
   assign ack_d1    = ack_d1_q;
   assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_dual_pull_resp.sv
// Scoreboard bench for dual_pull_resp: pushed words are queued and compared
// against the rails when each pull handshake completes.
module tb_dual_pull_resp;

   localparam int unsigned W = 128;
`ifdef DUAL_PULL_RESP_SYNC_EN
   localparam int Lat = 3;
`else
   localparam int Lat = 1;
`endif

   logic         clk = 1'b0;
   logic         initialise;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         req;
   logic [W-1:0] ack_d0;
   logic [W-1:0] ack_d1;
   logic [15:0]  rsp_count;

   int           n_total = 0;
   int           n_bad = 0;
   logic [W-1:0] exp_q[$];
   logic [15:0]  exp_cnt;
   logic         mon_en = 1'b0;

   always #5 clk = ~clk;

   dual_pull_resp #(
      .WIDTH (W),
      .DEPTH (2)
   ) dut (
      .clk        (clk),
      .initialise (initialise),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .req        (req),
      .ack_d0     (ack_d0),
      .ack_d1     (ack_d1),
      .rsp_count  (rsp_count)
   );

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) check_val("rail_overlap", ack_d0 & ack_d1, '0);
   end

   task automatic push_word(input logic [W-1:0] w);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (ok) exp_q.push_back(w);
      else check_val("push_timeout", W'(0), W'(1));
   endtask

   task automatic finish_hs(input logic [W-1:0] w);
      req = 1'b0;
      for (int i = 0; i < Lat; i++) begin
         @(negedge clk);
         if (i < Lat - 1) check_val("fall_hold_d0", ack_d0, ~w);
      end
      exp_cnt = exp_cnt + 16'd1;
      check_val("spacer_d1", ack_d1, '0);
      check_val("spacer_d0", ack_d0, '0);
      check_val("rsp_count", W'(rsp_count), W'(exp_cnt));
   endtask

   task automatic serve(input int hold);
      logic [W-1:0] w;
      if (exp_q.size() == 0) begin
         check_val("serve_empty", W'(0), W'(1));
         return;
      end
      w = exp_q.pop_front();
      check_val("pre_d1", ack_d1, '0);
      req = 1'b1;
      for (int i = 0; i < Lat; i++) begin
         @(negedge clk);
         if (i < Lat - 1) check_val("early_d1", ack_d1, '0);
      end
      check_val("cw_d1", ack_d1, w);
      check_val("cw_d0", ack_d0, ~w);
      repeat (hold) begin
         @(negedge clk);
         check_val("hold_d1", ack_d1, w);
      end
      finish_hs(w);
   endtask

   initial begin
      logic [W-1:0] w;
      initialise = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      req        = 1'b0;
      exp_cnt    = '0;
      repeat (2) @(negedge clk);
      check_val("rst_in_ready", W'(in_ready), W'(0));
      check_val("rst_d0", ack_d0, '0);
      check_val("rst_d1", ack_d1, '0);
      check_val("rst_rsp_count", W'(rsp_count), W'(0));
      mon_en = 1'b1;
      initialise = 1'b0;
      @(negedge clk);
      check_val("in_ready_rise", W'(in_ready), W'(1));

      // Basic pull handshake.
      push_word(128'h0f0e0d0c0b0a09080706050403020100);
      serve(2);

      // Request arrives before data.
      req = 1'b1;
      repeat (Lat + 3) begin
         @(negedge clk);
         check_val("wait_data_d1", ack_d1, '0);
      end
      push_word(128'hffeeddccbbaa99887766554433221100);
      check_val("no_bypass_d1", ack_d1, '0);
      @(negedge clk);
      w = exp_q.pop_front();
      check_val("late_cw_d1", ack_d1, w);
      check_val("late_cw_d0", ack_d0, ~w);
      finish_hs(w);

      // Full FIFO back-pressure and ordering.
      push_word(128'h1111_2222_3333_4444_5555_6666_7777_8888);
      push_word(128'hdead_beef_0000_ffff_a5a5_5a5a_0123_4567);
      check_val("full_in_ready", W'(in_ready), W'(0));
      fork
         push_word(128'hcafe_f00d_1234_5678_9abc_def0_0f0f_f0f0);
         begin
            repeat (3) begin
               @(negedge clk);
               check_val("held_in_ready", W'(in_ready), W'(0));
            end
            serve(0);
         end
      join
      serve(1);
      serve(0);

      // Reset in mid-handshake with a buffered word behind the driven one.
      push_word(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
      push_word(128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa);
      req = 1'b1;
      repeat (Lat) @(negedge clk);
      w = exp_q.pop_front();
      check_val("pre_rst_cw_d1", ack_d1, w);
      initialise = 1'b1;
      @(negedge clk);
      check_val("mid_rst_d0", ack_d0, '0);
      check_val("mid_rst_d1", ack_d1, '0);
      check_val("mid_rst_rsp", W'(rsp_count), W'(0));
      check_val("mid_rst_count", W'(dut.fifo_count), W'(0));
      initialise = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      @(negedge clk);
      check_val("post_rst_ready", W'(in_ready), W'(1));
      push_word(128'h7777_0000_7777_0000_7777_0000_7777_0001);
      repeat (5) begin
         @(negedge clk);
         check_val("req_high_d1", ack_d1, '0);
      end
      req = 1'b0;
      repeat (Lat + 2) @(negedge clk);
      serve(1);

      // Counter wrap from 0xFFFF.
      push_word(128'h9999_8888_7777_6666_5555_4444_3333_2222);
      force dut.rsp_count_q = 16'hffff;
      @(negedge clk);
      release dut.rsp_count_q;
      exp_cnt = 16'hffff;
      @(negedge clk);
      check_val("preset_rsp", W'(rsp_count), W'(16'hffff));
      serve(1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dual_pull_resp.md
DUAL_PULL_RESP -- requirements
Module: dual_pull_resp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the data bits carried per handshake.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of entries in the input buffer; legal values are 1 to 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port initialise, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the synchronous producer offers in_data.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the buffer accepts a word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the word to serve.
REQ-008 The block SHALL have port req, input, 1 bit: the pull request from a Balsa dual-rail pull channel (for example key__in_0r).
REQ-009 The block SHALL have port ack_d0, output, WIDTH bits: the dual-rail zero rails.
REQ-010 The block SHALL have port ack_d1, output, WIDTH bits: the dual-rail one rails.
REQ-011 The block SHALL have port rsp_count, output, 16 bits: the number of completed four-phase handshakes.

Function
REQ-012 The block SHALL act as the passive, data-bearing end of a four-phase return-to-zero pull channel: req rises, data is placed on the rails, req falls, the rails return to spacer.
REQ-013 Spacer SHALL mean ack_d0 = 0 and ack_d1 = 0; a valid codeword SHALL be ack_d1 = D and ack_d0 = ~D, where D is the popped word.
REQ-014 The buffer SHALL be a FIFO of DEPTH entries.
REQ-015 in_ready SHALL equal (count < DEPTH), so a push occurs when in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 0 when the FIFO is full, even in a cycle where a pop occurs.
REQ-017 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-018 There SHALL be no bypass path: a word pushed at edge N can be popped no earlier than edge N+1.
REQ-019 req_s SHALL denote req after the optional synchronizer (see REQ-030 and REQ-031).
REQ-020 The state machine SHALL have states WAIT_LOW, IDLE, WAIT_DATA and DRIVE.
REQ-021 In WAIT_LOW, when req_s = 0 the block SHALL go to IDLE; the rails stay at spacer.
REQ-022 In IDLE, when req_s = 1 and count > 0 the block SHALL pop, register the codeword onto the rails and go to DRIVE; when req_s = 1 and count = 0 it SHALL go to WAIT_DATA.
REQ-023 In WAIT_DATA, when count > 0 the block SHALL pop, drive the codeword and go to DRIVE.
REQ-024 In WAIT_DATA, a fall of req_s SHALL be ignored, because withdrawal of a request is illegal in the protocol.
REQ-025 In DRIVE, the rails SHALL hold their codeword stable while req_s = 1.
REQ-026 In DRIVE, when req_s = 0 the block SHALL return the rails to spacer, increment rsp_count and go to IDLE, all on the same edge.
REQ-027 rsp_count SHALL wrap from 0xFFFF to 0x0000.
REQ-028 The rails SHALL be driven directly from flops, with no combinational path from req to ack_d0 or ack_d1.
REQ-029 No output SHALL ever present a bit position with ack_d0 = ack_d1 = 1.

Configuration
REQ-030 With DUAL_PULL_RESP_SYNC_EN defined, req SHALL pass through a two-flop synchronizer, so the rails change 3 edges after req changes, given data is available.
REQ-031 Without DUAL_PULL_RESP_SYNC_EN, req_s SHALL equal req, so the rails change 1 edge after req changes.

Reset
REQ-032 While initialise = 1 at a clock edge, the block SHALL clear the FIFO (count = 0), set in_ready = 0, set the rails to spacer, clear rsp_count, clear the synchronizer flops and set the state to WAIT_LOW.
REQ-033 After reset, in_ready SHALL rise on the first edge at which initialise = 0.
REQ-034 Reset in mid-handshake SHALL discard the word being driven and any buffered words.
REQ-035 If req is still high after reset, the block SHALL not respond until req has been seen low.

Structure
REQ-036 A shared package dual_rail_pkg SHALL hold the state enumeration and a dual-rail encode function (D to {~D, D}), for reuse by other channel adapters.
REQ-037 The FIFO SHALL be a sub-module dual_pull_resp_fifo (parameters WIDTH and DEPTH; push, pop, count, head data); the FSM and rail registers stay in the top level.

Verification
REQ-038 Without the sync macro, push 0x0f0e0d0c0b0a09080706050403020100, then raise req -> one edge later ack_d1 = that word and ack_d0 = its complement; drop req -> rails = 0 and rsp_count = 1 one edge later.
REQ-039 With the sync macro, raise req with the FIFO empty -> rails stay at spacer (state WAIT_DATA); push 0xffeeddccbbaa99887766554433221100 -> the codeword appears one edge after the push is accepted.
REQ-040 With DEPTH = 2, push three words while req stays low -> in_ready = 0 after the second push; the third word is held by the producer until a pop, and the words are served in order.
REQ-041 Assert initialise with req high and the rails in DRIVE -> rails = 0, rsp_count = 0 and count = 0; no codeword appears until req falls and rises again.
REQ-042 Preset rsp_count by forcing it to 0xFFFF and complete one handshake -> rsp_count = 0x0000; check on every cycle that no bit has both rails high.
